// File: rtl/state_seq_ctrl_pkg.sv
// seq_ctrl_pkg: state codes and shared helpers for the instruction sequencer.
package seq_ctrl_pkg;
    typedef enum logic [4:0] {
        IF0 = 5'd0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1,
        MUL1, MUL2_1, MUL2_2, MUL3, MUL4, IT0, IT1, IT2
    } state_e;

    function automatic int bus_err_id(input int num_irq);
        return num_irq + 1;
    endfunction
endpackage

// File: rtl/state_seq_ctrl_if.sv
// state_seq_ctrl_if: handshake, instruction-decode and interrupt signals of the sequencer.
interface state_seq_ctrl_if #(
    parameter int NUM_IRQ = 4,
    parameter int MUL_STEPS = 16
);
    logic ack, from_d, to_d, op_mul, op_svc, op_rit;
    logic [NUM_IRQ-1:0] irq_req, irq_mask;
    logic [4:0] state_o;
    logic [$clog2(MUL_STEPS)-1:0] mul_cnt;
    logic ita, itf, bus_err;
    logic [$clog2(NUM_IRQ+2)-1:0] irq_id;

    modport master (
        output ack, from_d, to_d, op_mul, op_svc, op_rit, irq_req, irq_mask,
        input state_o, mul_cnt, ita, itf, irq_id, bus_err
    );
    modport slave (
        input ack, from_d, to_d, op_mul, op_svc, op_rit, irq_req, irq_mask,
        output state_o, mul_cnt, ita, itf, irq_id, bus_err
    );
endinterface

// File: rtl/state_seq_ctrl_irq_prio_enc.sv
// irq_prio_enc: SVC first (id 0), then lowest-index unmasked channel i (id i+1).
module irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int IW = $clog2(NUM_IRQ + 2)
) (
    input  logic               svc,
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IW-1:0]      id
);
    always_comb begin
        valid = svc | (|req);
        id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) id = req[i] ? IW'(i + 1) : id;
        id = svc ? '0 : id;
    end
endmodule

// File: rtl/state_seq_ctrl.sv
// state_seq_ctrl: fetch/execute sequencer with MUL loop and prioritised interrupt entry.
// Define STATE_SEQ_ACK_TIMEOUT_EN to bound ACK waits and pulse bus_err on expiry.
module state_seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int MUL_STEPS = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input logic clk,
    input logic reset,
    state_seq_ctrl_if.slave s
);
    localparam int MW = $clog2(MUL_STEPS);
    localparam int IW = $clog2(NUM_IRQ + 2);
    localparam logic [IW-1:0] BERR_ID = IW'(bus_err_id(NUM_IRQ));
    localparam logic [MW-1:0] MUL_LAST = MW'(MUL_STEPS - 1);

    state_e state;
    logic [MW-1:0] mul_cnt;
    logic [IW-1:0] irq_id, enc_id;
    logic [NUM_IRQ-1:0] pending, clr;
    logic itf, svc_pending, enc_valid, ita, wait_if, timeout;

    if (NUM_IRQ < 1 || NUM_IRQ > 16 || MUL_STEPS < 2 || MUL_STEPS > 64 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("state_seq_ctrl: parameter out of range");
    end

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .IW(IW)) u_enc (
        .svc(svc_pending),
        .req(pending & ~s.irq_mask),
        .valid(enc_valid),
        .id(enc_id)
    );

    assign ita = itf & enc_valid;
    assign wait_if = state inside {IF0, FF0, TF0};

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) clr[i] = state == IT2 && irq_id == IW'(i + 1);
    end

`ifdef STATE_SEQ_ACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tcnt;
    logic wait_st;
    assign wait_st = wait_if || state inside {IT0, IT1};
    assign timeout = wait_st && !s.ack && tcnt == TW'(TIMEOUT_CYC - 1);
    assign s.bus_err = timeout;
    // Any ack or leaving a wait state restarts the count.
    always_ff @(posedge clk)
        tcnt <= (reset || !wait_st || s.ack || timeout) ? '0 : tcnt + 1'b1;
`else
    assign timeout = 1'b0;
    assign s.bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IF0;
            mul_cnt <= '0;
            itf <= 1'b0;
            irq_id <= '0;
            pending <= '0;
            svc_pending <= 1'b0;
        end else begin
            // A request in the same cycle as the IT2 clear keeps the bit set.
            pending <= s.irq_req | (pending & ~clr);
            svc_pending <= (state == EX0 && s.op_svc) | (svc_pending & !(state == IT2 && irq_id == '0));
            if (timeout) begin
                state <= wait_if ? IT0 : IF0;
                if (wait_if) begin
                    irq_id <= BERR_ID;
                    itf <= 1'b0;
                end
            end else begin
                case (state)
                    IF0: state <= s.ack ? IF1 : IF0;
                    IF1: state <= !s.from_d ? FF0 : !s.to_d ? TF0 : EX0;
                    FF0: state <= s.ack ? FF1 : FF0;
                    FF1: state <= FF2;
                    FF2: state <= s.to_d ? EX0 : TF0;
                    TF0: state <= s.ack ? TF1 : TF0;
                    TF1: state <= EX0;
                    EX0: state <= s.op_mul ? MUL1 : EX1;
                    MUL1: begin
                        state <= MUL2_1;
                        mul_cnt <= '0;
                    end
                    MUL2_1: state <= MUL2_2;
                    MUL2_2: begin
                        state <= mul_cnt != MUL_LAST ? MUL2_1 : MUL3;
                        if (mul_cnt != MUL_LAST) mul_cnt <= mul_cnt + 1'b1;
                    end
                    MUL3: state <= MUL4;
                    MUL4: state <= EX1;
                    EX1: begin
                        state <= ita ? IT0 : IF0;
                        if (ita) begin
                            irq_id <= enc_id;
                            itf <= 1'b0;
                        end else if (s.op_rit) begin
                            itf <= 1'b1;
                        end
                    end
                    IT0: state <= s.ack ? IT1 : IT0;
                    IT1: state <= s.ack ? IT2 : IT1;
                    IT2: state <= IF0;
                    default: state <= IF0;
                endcase
            end
        end
    end

    assign s.state_o = state;
    assign s.mul_cnt = mul_cnt;
    assign s.ita = ita;
    assign s.itf = itf;
    assign s.irq_id = irq_id;
endmodule
